// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one imem request at a time,
// holds the fetched word until decode takes it. Optional counters: FETCH_CTRL_PERF_EN.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_stall,
    input  logic        i_b_taken,
    input  logic [31:0] i_b_pc,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_data,
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc
`ifdef FETCH_CTRL_PERF_EN
    ,
    output logic [31:0] o_fetch_cnt,
    output logic [31:0] o_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_VALID,
        S_DRAIN
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] opc_q, opc_d;
    logic [31:0] b_tgt;

    // Redirect targets are word aligned; the low bits of i_b_pc are dropped.
    assign b_tgt = i_b_pc & ~32'h0000_0003;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        opc_d   = opc_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
                if (i_b_taken) begin
                    pc_d   = b_tgt;
                    addr_d = b_tgt;
                end else begin
                    addr_d = pc_q;
                end
            end
            S_FETCH: begin
                if (i_b_taken) begin
                    pc_d = b_tgt;
                    if (i_imem_ack) begin
                        addr_d = b_tgt;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end else if (i_imem_ack) begin
                    instr_d = i_imem_data;
                    opc_d   = addr_q;
                    pc_d    = addr_q + 32'd4;
                    state_d = S_VALID;
                end
            end
            S_VALID: begin
                if (i_b_taken) begin
                    pc_d    = b_tgt;
                    addr_d  = b_tgt;
                    state_d = S_FETCH;
                end else if (!i_stall) begin
                    addr_d  = pc_q;
                    state_d = S_FETCH;
                end
            end
            S_DRAIN: begin
                // The in-flight request is stale: keep it stable and discard its data.
                if (i_b_taken) begin
                    pc_d = b_tgt;
                    if (i_imem_ack) begin
                        addr_d  = b_tgt;
                        state_d = S_FETCH;
                    end
                end else if (i_imem_ack) begin
                    addr_d  = pc_q;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            instr_q <= NOP_INSTR;
            opc_q   <= RESET_PC;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            opc_q   <= opc_d;
        end
    end

    assign o_imem_req  = (state_q == S_FETCH) || (state_q == S_DRAIN);
    assign o_valid     = (state_q == S_VALID);
    assign o_imem_addr = addr_q;
    assign o_instr     = instr_q;
    assign o_pc        = opc_q;

`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (state_q == S_VALID) begin
            if (i_stall) begin
                stall_cnt_d = stall_cnt_q + 32'd1;
            end else if (!i_b_taken) begin
                fetch_cnt_d = fetch_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign o_fetch_cnt = fetch_cnt_q;
    assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Sequencer for the instruction-fetch stage of the RISC-V pipeline. Owns the program counter, issues one request at a time to instruction memory over a req/ack handshake, and holds the fetched instruction until decode accepts it. Applies branch redirects from execute, including redirects that arrive while a request is still outstanding. Sits between the PC/next-PC datapath and the IF/ID boundary.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP_INSTR, 32'h0000_0013, value of o_instr at reset (addi x0,x0,0)

- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_stall  in  1  decode cannot accept the presented instruction this cycle
- i_b_taken  in  1  redirect strobe from execute, single-cycle
- i_b_pc  in  32  redirect target, valid with i_b_taken
- o_imem_req  out  1  instruction memory request
- o_imem_addr  out  32  request address, stable while o_imem_req=1
- i_imem_ack  in  1  response strobe, single-cycle, may arrive in the first req cycle
- i_imem_data  in  32  instruction word, valid with i_imem_ack
- o_valid  out  1  o_instr/o_pc hold a fetched instruction
- o_instr  out  32  fetched instruction
- o_pc  out  32  address of o_instr
- o_fetch_cnt  out  32  instructions delivered (FETCH_CTRL_PERF_EN only)
- o_stall_cnt  out  32  cycles with o_valid=1 and i_stall=1 (FETCH_CTRL_PERF_EN only)

## Operation
- Registers: state, pc (next fetch address), o_imem_addr, o_instr, o_pc, o_valid.
- States: IDLE, FETCH, VALID, DRAIN. Moore outputs: o_imem_req=1 in FETCH and DRAIN only; o_valid=1 in VALID only.
- IDLE: reset state; unconditionally → FETCH, o_imem_addr<=pc.
- FETCH: wait for i_imem_ack. On ack: o_instr<=i_imem_data, o_pc<=o_imem_addr, pc<=o_imem_addr+4 → VALID.
- VALID: if i_stall, hold all outputs. If !i_stall, instruction consumed: o_imem_addr<=pc → FETCH.
- DRAIN: request with stale address in flight; keep req and address. On ack: discard data, o_imem_addr<=pc → FETCH.
- Redirect (i_b_taken=1) has priority over ack and stall in every state: pc<=i_b_pc with bits [1:0] forced to 0.
  - IDLE or VALID: o_imem_addr<=target → FETCH; instruction in VALID is dropped.
  - FETCH with ack in the same cycle: data discarded, o_imem_addr<=target → FETCH.
  - FETCH without ack: → DRAIN.
  - DRAIN: target overwritten by newest i_b_pc, stay DRAIN unless ack, in which case → FETCH at newest target.
- pc+4 is modulo 2^32: 32'hFFFF_FFFC wraps to 32'h0000_0000.
- An ack outside FETCH/DRAIN is ignored.

## Timing
- Reset values: state=IDLE, pc=RESET_PC, o_imem_addr=RESET_PC, o_imem_req=0, o_valid=0, o_instr=NOP_INSTR, o_pc=RESET_PC, counters=0.
- Reset is asynchronous. Asserting it mid-request forces reset values immediately. The outstanding memory response is not tracked.
- First o_imem_req is one cycle after reset release. Ack in cycle N gives o_valid=1 in cycle N+1.
- Zero-wait memory, no stall: one instruction per 2 cycles. o_imem_req and o_valid are never both high.
- Redirect in cycle N: o_valid=0 from N+1. The first request to the target is in N+1, or in the cycle after the draining ack.

## Configuration
- FETCH_CTRL_PERF_EN defined: o_fetch_cnt increments on every VALID cycle with !i_stall and !i_b_taken. o_stall_cnt increments on every VALID cycle with i_stall=1. Both wrap at 2^32 and reset to 0.
- Not defined: both ports are absent and no counter logic is built.

## Test plan
- Reset release, RESET_PC=0, ack same cycle as req, data 32'h00A00093 -> req addr 0 in cycle 1; o_valid, o_pc=0, o_instr=32'h00A00093 in cycle 2; next req addr 4 in cycle 3.
- i_stall=1 for 3 cycles while VALID -> o_valid, o_pc, o_instr unchanged, o_imem_req=0; req addr o_pc+4 in the cycle after i_stall drops. With PERF: o_stall_cnt=3.
- Req at 0x8, ack delayed 3 cycles, i_b_taken with 0x100 in the first req cycle -> addr stays 0x8 until ack, data discarded, o_valid stays 0, next req addr 0x100.
- i_b_taken=1 with i_b_pc=0x203, together with i_stall=1 in VALID -> o_valid=0 next cycle, req addr 0x200.
- pc at 32'hFFFFFFFC, instruction consumed -> next req addr 32'h00000000.
- i_rst_n low while FETCH outstanding -> same cycle o_imem_req=0, o_valid=0, o_instr=32'h00000013; after release, req addr RESET_PC.
